// File: rtl/stack_unit_if.sv
// stack_unit_if: command/data bundle between controller, datapath and stack.
// master drives strobes and write data, slave returns read data and status.
interface stack_unit_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             push;
    logic             pop;
    logic             tos;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output push,
        output pop,
        output tos,
        output din,
        output clr_err,
        input  dout,
        input  count,
        input  empty,
        input  full,
        input  ovf,
        input  unf
    );

    modport slave (
        input  push,
        input  pop,
        input  tos,
        input  din,
        input  clr_err,
        output dout,
        output count,
        output empty,
        output full,
        output ovf,
        output unf
    );
endinterface

// File: rtl/stack_unit.sv
// stack_unit: operand stack for the multicycle stack-machine CPU.
// Registered one-cycle read, same-edge write, sticky ovf/unf errors.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    stack_unit_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      sp;
    logic [WIDTH-1:0] dout_q;
    logic             ovf_q;
    logic             unf_q;

    logic             is_empty;
    logic             is_full;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] top_val;

    logic [AW:0]      sp_nxt;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             rd_en;
    logic             set_ovf;
    logic             set_unf;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == FULL_CNT);
    // Wraps harmlessly when sp is 0 or DEPTH; only used when not empty.
    assign top_idx  = sp[AW-1:0] - AW'(1);
    assign top_val  = mem[top_idx];

    // Decode one command per cycle; cases are mutually exclusive.
    always_comb begin
        sp_nxt  = sp;
        wr_en   = 1'b0;
        wr_addr = sp[AW-1:0];
        rd_en   = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        unique case (1'b1)
            bus.push && bus.pop && !is_empty: begin
                wr_en   = 1'b1;
                wr_addr = top_idx;
                rd_en   = 1'b1;
            end
            bus.push && bus.pop && is_empty: begin
                set_unf = 1'b1;
                wr_en   = 1'b1;
                wr_addr = '0;
                sp_nxt  = (AW+1)'(1);
            end
            bus.push && !bus.pop && !is_full: begin
                wr_en   = 1'b1;
                sp_nxt  = sp + (AW+1)'(1);
            end
            bus.push && !bus.pop && is_full: begin
                set_ovf = 1'b1;
            end
            !bus.push && bus.pop && !is_empty: begin
                rd_en   = 1'b1;
                sp_nxt  = sp - (AW+1)'(1);
            end
            !bus.push && bus.pop && is_empty: begin
                set_unf = 1'b1;
            end
            !bus.push && !bus.pop && bus.tos && !is_empty: begin
                rd_en   = 1'b1;
            end
            !bus.push && !bus.pop && bus.tos && is_empty: begin
                set_unf = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Pointer, read register and sticky errors; set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp     <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            sp <= sp_nxt;
            if (rd_en)
                dout_q <= top_val;
            if (set_ovf)
                ovf_q <= 1'b1;
            else if (bus.clr_err)
                ovf_q <= 1'b0;
            if (set_unf)
                unf_q <= 1'b1;
            else if (bus.clr_err)
                unf_q <= 1'b0;
        end
    end

    // Storage array, deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= bus.din;
    end

    assign bus.dout  = dout_q;
    assign bus.count = sp;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed scoreboard bench for stack_unit.
// Read results are queued at drive time and compared one edge later.
module tb_stack_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;

    stack_unit_if #(.WIDTH(8), .DEPTH(16)) bif ();

    stack_unit #(.WIDTH(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq [$];
    logic [7:0] sb [$];
    logic [7:0] m_dout = 8'h00;
    bit         m_ovf  = 1'b0;
    bit         m_unf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".count"}, 32'(bif.count), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(bif.empty), 32'(mq.size() == 0));
        chk({tag, ".full"},  32'(bif.full),  32'(mq.size() == 16));
        chk({tag, ".ovf"},   32'(bif.ovf),   32'(m_ovf));
        chk({tag, ".unf"},   32'(bif.unf),   32'(m_unf));
        chk({tag, ".dout"},  32'(bif.dout),  32'(m_dout));
    endtask

    // Called at a negedge: model the command, drive it, clock it, compare.
    task automatic op(input bit pu, input bit po, input bit to,
                      input logic [7:0] d, input bit cl, input string tag);
        bit so = 0;
        bit su = 0;
        bit rd = 0;
        if (pu && po) begin
            if (mq.size() > 0) begin
                m_dout = mq[$];
                mq[$]  = d;
                rd     = 1;
            end else begin
                su = 1;
                mq.push_back(d);
            end
        end else if (pu) begin
            if (mq.size() < 16) mq.push_back(d);
            else so = 1;
        end else if (po) begin
            if (mq.size() > 0) begin
                m_dout = mq.pop_back();
                rd     = 1;
            end else su = 1;
        end else if (to) begin
            if (mq.size() > 0) begin
                m_dout = mq[$];
                rd     = 1;
            end else su = 1;
        end
        if (cl) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (so) m_ovf = 1;
        if (su) m_unf = 1;
        if (rd) sb.push_back(m_dout);

        bif.push    = pu;
        bif.pop     = po;
        bif.tos     = to;
        bif.din     = d;
        bif.clr_err = cl;
        @(posedge clk);
        @(negedge clk);
        bif.push    = 0;
        bif.pop     = 0;
        bif.tos     = 0;
        bif.clr_err = 0;

        if (rd) begin
            logic [7:0] e;
            e = sb.pop_front();
            chk({tag, ".rd"}, 32'(bif.dout), 32'(e));
        end
        chk_status(tag);
    endtask

    initial begin
        bif.push    = 0;
        bif.pop     = 0;
        bif.tos     = 0;
        bif.din     = 8'h00;
        bif.clr_err = 0;

        // Reset state.
        #2;
        chk("rst.count", 32'(bif.count), 0);
        chk("rst.empty", 32'(bif.empty), 1);
        chk("rst.full",  32'(bif.full),  0);
        chk("rst.dout",  32'(bif.dout),  0);
        chk("rst.ovf",   32'(bif.ovf),   0);
        chk("rst.unf",   32'(bif.unf),   0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Pushes then peek.
        op(1, 0, 0, 8'h11, 0, "push11");
        op(1, 0, 0, 8'h22, 0, "push22");
        op(1, 0, 0, 8'h33, 0, "push33");
        chk("p3.count", 32'(bif.count), 3);
        op(0, 0, 1, 8'h00, 0, "tos33");
        chk("tos.dout", 32'(bif.dout), 32'h33);
        chk("tos.count", 32'(bif.count), 3);

        // Pop order and underflow.
        op(0, 1, 0, 8'h00, 0, "pop1");
        chk("pop1.dout", 32'(bif.dout), 32'h33);
        op(0, 1, 0, 8'h00, 0, "pop2");
        chk("pop2.dout", 32'(bif.dout), 32'h22);
        op(0, 1, 0, 8'h00, 0, "pop3");
        chk("pop3.dout", 32'(bif.dout), 32'h11);
        chk("pop3.empty", 32'(bif.empty), 1);
        chk("pop3.unf", 32'(bif.unf), 0);
        op(0, 1, 0, 8'h00, 0, "popunf");
        chk("popunf.unf", 32'(bif.unf), 1);
        chk("popunf.dout", 32'(bif.dout), 32'h11);
        chk("popunf.count", 32'(bif.count), 0);

        // Fill to DEPTH and overflow.
        for (int i = 0; i < 16; i++) begin
            chk("fill.notfull", 32'(bif.full), 0);
            op(1, 0, 0, 8'(i), 0, "fill");
        end
        chk("fill.full", 32'(bif.full), 1);
        chk("fill.count", 32'(bif.count), 16);
        op(1, 0, 0, 8'hAA, 0, "pushovf");
        chk("ovf.flag", 32'(bif.ovf), 1);
        chk("ovf.count", 32'(bif.count), 16);
        op(0, 1, 0, 8'h00, 0, "popfull");
        chk("popfull.dout", 32'(bif.dout), 32'h0F);
        chk("popfull.full", 32'(bif.full), 0);

        // Error clear, then set beats clear.
        op(0, 0, 0, 8'h00, 1, "clr");
        chk("clr.ovf", 32'(bif.ovf), 0);
        chk("clr.unf", 32'(bif.unf), 0);
        for (int i = 0; i < 15; i++)
            op(0, 1, 0, 8'h00, 0, "drain");
        op(0, 1, 0, 8'h00, 1, "clrpop");
        chk("clrpop.unf", 32'(bif.unf), 1);
        op(0, 0, 0, 8'h00, 1, "clr2");

        // Replace and push+pop on empty; tos ignored under push.
        op(1, 0, 0, 8'h05, 0, "push05");
        op(1, 0, 0, 8'h07, 0, "push07");
        op(1, 1, 0, 8'h09, 0, "repl");
        chk("repl.dout", 32'(bif.dout), 32'h07);
        chk("repl.count", 32'(bif.count), 2);
        op(0, 0, 1, 8'h00, 0, "tos09");
        chk("tos09.dout", 32'(bif.dout), 32'h09);
        op(1, 0, 1, 8'h5A, 0, "pushtos");
        op(0, 1, 0, 8'h00, 0, "dr1");
        op(0, 1, 0, 8'h00, 0, "dr2");
        op(0, 1, 0, 8'h00, 0, "dr3");
        op(1, 1, 0, 8'h3C, 0, "replemp");
        chk("replemp.unf", 32'(bif.unf), 1);
        chk("replemp.count", 32'(bif.count), 1);
        op(0, 0, 1, 8'h00, 0, "tos3c");
        chk("tos3c.dout", 32'(bif.dout), 32'h3C);

        // Asynchronous reset between edges.
        for (int i = 0; i < 5; i++)
            op(1, 0, 0, 8'(8'h60 + i), 0, "pre");
        op(0, 0, 1, 8'h00, 0, "pretos");
        #2;
        rst = 1'b0;
        #1;
        chk("arst.count", 32'(bif.count), 0);
        chk("arst.dout",  32'(bif.dout),  0);
        chk("arst.ovf",   32'(bif.ovf),   0);
        chk("arst.unf",   32'(bif.unf),   0);
        chk("arst.empty", 32'(bif.empty), 1);
        mq.delete();
        m_dout = 8'h00;
        m_ovf  = 0;
        m_unf  = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        op(1, 0, 0, 8'h44, 0, "push44");
        op(0, 0, 1, 8'h00, 0, "tos44");
        chk("tos44.dout", 32'(bif.dout), 32'h44);
        chk("sb.empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
